// File: rtl/lcd_spi_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_spi_sequencer_if
// Brief    : SPI transmitter handshake, status and fill-request bundle for
//            lcd_spi_sequencer. The master modport is the sequencer's view and
//            the slave modport is the view of the block around it.
// Revision : 1.0  initial release
// ============================================================================
interface lcd_spi_sequencer_if #(
  parameter int COORD_W = 9
) ();
  logic               spi_busy;
  logic               spi_load;
  logic               spi_load16;
  logic [15:0]        spi_in;
  logic               init_done;
  logic               ready;
  logic               fill_req;
  logic [COORD_W-1:0] fill_x0;
  logic [COORD_W-1:0] fill_x1;
  logic [COORD_W-1:0] fill_y0;
  logic [COORD_W-1:0] fill_y1;
  logic [15:0]        fill_color;
  logic               fill_done;
  logic               fill_err;

  modport master (
    input  spi_busy, fill_req, fill_x0, fill_x1, fill_y0, fill_y1, fill_color,
    output spi_load, spi_load16, spi_in, init_done, ready, fill_done, fill_err
  );

  modport slave (
    output spi_busy, fill_req, fill_x0, fill_x1, fill_y0, fill_y1, fill_color,
    input  spi_load, spi_load16, spi_in, init_done, ready, fill_done, fill_err
  );
endinterface
`default_nettype wire

// File: rtl/lcd_spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_spi_sequencer
// Brief    : Sole driver of the SPI LCD transmitter. Plays the power-up ROM
//            (commands, data, ms delays), then serves rectangle fills:
//            column/row window, RAMWR, and one 16-bit colour word per pixel.
// Revision : 1.0  initial release
// ============================================================================
module lcd_spi_sequencer #(
  parameter int CLK_PER_MS = 25000,
  parameter int COORD_W    = 9
) (
  input  logic                clk,
  input  logic                reset,
  lcd_spi_sequencer_if.master bus
);

  localparam int          PIX_W = 2 * COORD_W + 1;
  localparam logic [31:0] C_CLK_PER_MS = 32'(CLK_PER_MS);

  localparam logic [3:0] ST_BOOT_WAIT  = 4'd0;
  localparam logic [3:0] ST_INIT_FETCH = 4'd1;
  localparam logic [3:0] ST_INIT_DELAY = 4'd2;
  localparam logic [3:0] ST_IDLE       = 4'd3;
  localparam logic [3:0] ST_FILL_HDR   = 4'd4;
  localparam logic [3:0] ST_FILL_PIX   = 4'd5;
  localparam logic [3:0] ST_ISSUE      = 4'd6;
  localparam logic [3:0] ST_ARM        = 4'd7;
  localparam logic [3:0] ST_WAIT       = 4'd8;

  logic [3:0]         state_q, state_d, ret_q, ret_d;
  logic [3:0]         rom_idx_q, rom_idx_d, hdr_idx_q, hdr_idx_d;
  logic [31:0]        dly_q, dly_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [COORD_W-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [15:0]        color_q, color_d, spi_in_q, spi_in_d;
  logic               spi_load_q, spi_load_d, spi_load16_q, spi_load16_d;
  logic               init_done_q, init_done_d, fill_err_q, fill_err_d;

  logic [15:0]        w_rom;
  logic [7:0]         w_hdr_byte;
  logic               w_hdr_dcx;
  logic [COORD_W:0]   w_dx, w_dy;
  logic [PIX_W-1:0]   w_pix;
  logic [31:0]        w_dly;
  logic [15:0]        w_x0, w_x1, w_y0, w_y1;

  // Init ROM: [15:14] 00 cmd, 01 data, 10 delay (ms units in [13:0]), 11 end.
  always_comb begin
    w_rom = 16'hC000;
    case (rom_idx_q)
      4'd0:    w_rom = 16'h0001;
      4'd1:    w_rom = 16'h8096;
      4'd2:    w_rom = 16'h0011;
      4'd3:    w_rom = 16'h800A;
      4'd4:    w_rom = 16'h003A;
      4'd5:    w_rom = 16'h4055;
      4'd6:    w_rom = 16'h0036;
      4'd7:    w_rom = 16'h4000;
      4'd8:    w_rom = 16'h0021;
      4'd9:    w_rom = 16'h0013;
      4'd10:   w_rom = 16'h0029;
      4'd11:   w_rom = 16'h800A;
      default: w_rom = 16'hC000;
    endcase
  end

  assign w_dly = 32'(w_rom[13:0]) * C_CLK_PER_MS;

  // Inclusive extents; one extra bit so a full-width span cannot wrap.
  assign w_dx  = {1'b0, bus.fill_x1} - {1'b0, bus.fill_x0} + 1'b1;
  assign w_dy  = {1'b0, bus.fill_y1} - {1'b0, bus.fill_y0} + 1'b1;
  assign w_pix = PIX_W'(w_dx) * PIX_W'(w_dy);

  assign w_x0 = 16'(x0_q);
  assign w_x1 = 16'(x1_q);
  assign w_y0 = 16'(y0_q);
  assign w_y1 = 16'(y1_q);

  // Window header byte selection: CASET, 4 bytes, RASET, 4 bytes, RAMWR.
  always_comb begin
    w_hdr_byte = 8'h2C;
    w_hdr_dcx  = 1'b1;
    case (hdr_idx_q)
      4'd0:    begin w_hdr_byte = 8'h2A; w_hdr_dcx = 1'b0; end
      4'd1:    w_hdr_byte = w_x0[15:8];
      4'd2:    w_hdr_byte = w_x0[7:0];
      4'd3:    w_hdr_byte = w_x1[15:8];
      4'd4:    w_hdr_byte = w_x1[7:0];
      4'd5:    begin w_hdr_byte = 8'h2B; w_hdr_dcx = 1'b0; end
      4'd6:    w_hdr_byte = w_y0[15:8];
      4'd7:    w_hdr_byte = w_y0[7:0];
      4'd8:    w_hdr_byte = w_y1[15:8];
      4'd9:    w_hdr_byte = w_y1[7:0];
      default: begin w_hdr_byte = 8'h2C; w_hdr_dcx = 1'b0; end
    endcase
  end

  // Next-state logic; every transfer runs ISSUE -> ARM -> WAIT -> ret_q.
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    rom_idx_d    = rom_idx_q;
    hdr_idx_d    = hdr_idx_q;
    dly_d        = dly_q;
    pix_d        = pix_q;
    x0_d         = x0_q;
    x1_d         = x1_q;
    y0_d         = y0_q;
    y1_d         = y1_q;
    color_d      = color_q;
    spi_in_d     = spi_in_q;
    spi_load_d   = 1'b0;
    spi_load16_d = 1'b0;
    init_done_d  = init_done_q;
    fill_err_d   = 1'b0;
    case (state_q)
      ST_BOOT_WAIT: if (!bus.spi_busy) state_d = ST_INIT_FETCH;
      ST_INIT_FETCH: begin
        case (w_rom[15:14])
          2'b00, 2'b01: begin
            spi_load_d = 1'b1;
            spi_in_d   = {6'b0, w_rom[14], 1'b0, w_rom[7:0]};
            rom_idx_d  = rom_idx_q + 4'd1;
            ret_d      = ST_INIT_FETCH;
            state_d    = ST_ISSUE;
          end
          2'b10: begin
            dly_d     = w_dly;
            rom_idx_d = rom_idx_q + 4'd1;
            state_d   = ST_INIT_DELAY;
          end
          default: begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end
        endcase
      end
      ST_INIT_DELAY: begin
        if (dly_q <= 32'd1) state_d = ST_INIT_FETCH;
        else                dly_d   = dly_q - 32'd1;
      end
      ST_IDLE: begin
        if (bus.fill_req && init_done_q) begin
          x0_d    = bus.fill_x0;
          x1_d    = bus.fill_x1;
          y0_d    = bus.fill_y0;
          y1_d    = bus.fill_y1;
          color_d = bus.fill_color;
          if ((bus.fill_x1 < bus.fill_x0) || (bus.fill_y1 < bus.fill_y0)) begin
            fill_err_d = 1'b1;
          end else begin
            hdr_idx_d = 4'd0;
            pix_d     = w_pix;
            state_d   = ST_FILL_HDR;
          end
        end
      end
      ST_FILL_HDR: begin
        spi_load_d = 1'b1;
        spi_in_d   = {6'b0, w_hdr_dcx, 1'b0, w_hdr_byte};
        hdr_idx_d  = hdr_idx_q + 4'd1;
        ret_d      = (hdr_idx_q == 4'd10) ? ST_FILL_PIX : ST_FILL_HDR;
        state_d    = ST_ISSUE;
      end
      ST_FILL_PIX: begin
        spi_load16_d = 1'b1;
        spi_in_d     = color_q;
        pix_d        = pix_q - 1'b1;
        ret_d        = (pix_q == PIX_W'(1)) ? ST_IDLE : ST_FILL_PIX;
        state_d      = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_ARM;
      ST_ARM:   state_d = ST_WAIT;
      ST_WAIT:  if (!bus.spi_busy) state_d = ret_q;
      default:  state_d = ST_BOOT_WAIT;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BOOT_WAIT;
      ret_q        <= ST_INIT_FETCH;
      rom_idx_q    <= 4'd0;
      hdr_idx_q    <= 4'd0;
      dly_q        <= 32'd0;
      pix_q        <= '0;
      x0_q         <= '0;
      x1_q         <= '0;
      y0_q         <= '0;
      y1_q         <= '0;
      color_q      <= 16'd0;
      spi_in_q     <= 16'd0;
      spi_load_q   <= 1'b0;
      spi_load16_q <= 1'b0;
      init_done_q  <= 1'b0;
      fill_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      rom_idx_q    <= rom_idx_d;
      hdr_idx_q    <= hdr_idx_d;
      dly_q        <= dly_d;
      pix_q        <= pix_d;
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      y0_q         <= y0_d;
      y1_q         <= y1_d;
      color_q      <= color_d;
      spi_in_q     <= spi_in_d;
      spi_load_q   <= spi_load_d;
      spi_load16_q <= spi_load16_d;
      init_done_q  <= init_done_d;
      fill_err_q   <= fill_err_d;
    end
  end

  assign bus.spi_load   = spi_load_q;
  assign bus.spi_load16 = spi_load16_q;
  assign bus.spi_in     = spi_in_q;
  assign bus.init_done  = init_done_q;
  assign bus.ready      = (state_q == ST_IDLE) && init_done_q;
  assign bus.fill_err   = fill_err_q;
  // Only a fill's last pixel returns to IDLE, so this marks its WAIT exit.
  assign bus.fill_done  = (state_q == ST_WAIT) && !bus.spi_busy && (ret_q == ST_IDLE);

endmodule
`default_nettype wire

// File: doc/lcd_spi_sequencer.md
Name: lcd_spi_sequencer

Overview:
Controller that sits in front of the SPI LCD transmitter and is the only block driving that transmitter's load, load16 and in inputs. After reset it plays a fixed power-up command sequence from an internal ROM, with programmable millisecond delays. It then accepts rectangle-fill requests: it sets the column and row windows, issues RAMWR, and streams a constant 16-bit colour for every pixel in the rectangle.

Parameters:
CLK_PER_MS, 25000, clk cycles per delay unit (25 MHz default; benches use a small value such as 4)
COORD_W, 9, width of each fill coordinate

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
spi_busy  in  1  transmitter busy flag (transmitter out[15])
spi_load  out  1  one-cycle strobe: send byte, in[9]=DCX, in[7:0]=byte
spi_load16  out  1  one-cycle strobe: send 16-bit pixel word (DCX=1)
spi_in  out  16  word presented to transmitter
init_done  out  1  high once the init ROM has finished; cleared only by reset
ready  out  1  high in IDLE when init_done=1
fill_req  in  1  start fill; sampled only when ready=1
fill_x0  in  COORD_W  start column
fill_x1  in  COORD_W  end column, inclusive
fill_y0  in  COORD_W  start row
fill_y1  in  COORD_W  end row, inclusive
fill_color  in  16  RGB565 colour
fill_done  out  1  one-cycle pulse when the last pixel transfer completes
fill_err  out  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset values: spi_load=0, spi_load16=0, spi_in=0, init_done=0, ready=0, fill_done=0, fill_err=0. State becomes BOOT_WAIT, ROM index=0.
- spi_in holds its value from the ISSUE cycle until the next issue.
- SPI handshake, applied to every transfer:
  - ISSUE: exactly one of spi_load/spi_load16 is high for 1 cycle, with spi_in valid in the same cycle.
  - ARM: one cycle with no strobe, covering the transmitter's one-cycle busy latency.
  - WAIT: stay until spi_busy=0, then advance on the next cycle.
  - Never strobe while spi_busy=1.
- BOOT_WAIT: stay until spi_busy=0. This covers a reset that lands mid-transfer. Then go to INIT_FETCH.
- ROM entry format [15:14]: 00 command byte, spi_in={6'b0,1'b0,1'b0,b[7:0]}; 01 data byte, spi_in={6'b0,1'b1,1'b0,b[7:0]}; 10 delay of b[13:0] units; 11 END.
- ROM contents, in order:
  - cmd 01, delay 150
  - cmd 11, delay 10
  - cmd 3A, data 55
  - cmd 36, data 00
  - cmd 21, cmd 13, cmd 29
  - delay 10, END
- Delay: counts N*CLK_PER_MS cycles in INIT_DELAY. A delay of 0 lasts 1 cycle.
- END: set init_done=1, go to IDLE. ready=1 starting the following cycle.
- fill_req while ready=0 is ignored: no pulse, no latch.
- IDLE with fill_req=1:
  - Latch all fill inputs.
  - If x1<x0 or y1<y0, pulse fill_err the next cycle and stay in IDLE with no SPI traffic.
  - Otherwise drop ready and enter FILL_HDR.
- FILL_HDR: 11 byte transfers, in order:
  - cmd 2A; data x0[15:8], x0[7:0], x1[15:8], x1[7:0]
  - cmd 2B; data y0 hi/lo, y1 hi/lo
  - cmd 2C
  - Coordinates are zero-extended to 16 bits.
- FILL_PIX:
  - Pixel count P=(x1-x0+1)*(y1-y0+1), computed at 2*COORD_W+1 bits, no overflow.
  - Issue P load16 transfers of the latched colour, counting down to zero.
  - fill_done pulses in the cycle WAIT exits on the final pixel. The next cycle is IDLE with ready=1.
- Single pixel (x0=x1, y0=y1): P=1.
- reset during any state: immediately restores the reset values. Partial fills are abandoned, and init reruns through BOOT_WAIT.

Test Plan:
1. Bench runs the transmitter model (busy 1 cycle after strobe, high 34 cycles), with CLK_PER_MS=4 -> the byte stream is 01,11,3A,55,36,00,21,13,29 with DCX 0,0,0,1,0,1,0,0,0. The gap after 01 is ≥600 cycles and after 11 is ≥40. init_done rises after the final delay.
2. After init: fill x0=2,x1=3,y0=5,y1=5, color=F800 -> bytes 2A,00,02,00,03,2B,00,05,00,05,2C, then exactly 2 load16 with spi_in=F800. fill_done pulses once; ready returns to 1.
3. Fill x0=x1=0, y0=y1=0 -> 11 header bytes, 1 pixel word, fill_done.
4. Fill x0=7,x1=6 -> fill_err pulses one cycle, zero strobes, ready stays 1.
5. Assert fill_req during init, and again during a fill -> ignored; init/fill byte streams are unchanged.
6. Assert reset while in FILL_PIX with spi_busy=1 -> next cycle all outputs are at reset values. No strobe occurs until spi_busy=0, then the init stream restarts with 01.
